// File: rtl/array_wr_sched.sv
// Round-robin write scheduler and clear sweeper for a register array.
// Ports: i_req/i_idx/i_data per requester, o_gnt one-hot grant,
//   i_clr starts a DEPTH-cycle clear sweep, o_busy flags the sweep,
//   o_arr exports the array, o_stall_cnt (ARRAY_WR_SCHED_STALL_CNT_EN)
//   counts IDLE cycles with at least one ungranted request.
module array_wr_sched #(
  parameter int N_REQ = 4,
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req  [N_REQ],
  input  logic [$clog2(DEPTH)-1:0] i_idx  [N_REQ],
  input  logic [WIDTH-1:0]         i_data [N_REQ],
  output logic                     o_gnt  [N_REQ],
  input  logic                     i_clr,
  output logic                     o_busy,
  output logic [WIDTH-1:0]         o_arr  [DEPTH]
`ifdef ARRAY_WR_SCHED_STALL_CNT_EN
  ,
  output logic [7:0]               o_stall_cnt
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int RW = $clog2(N_REQ);

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     sidx_q, sidx_d;
  logic [WIDTH-1:0]  arr_q [DEPTH];
  logic [WIDTH-1:0]  arr_d [DEPTH];
  logic              busy_q, busy_d;

  logic [N_REQ-1:0]  req_v;
  logic [N_REQ-1:0]  gnt_v;
  logic [RW-1:0]     cand;
  logic [RW-1:0]     win;
  logic              found;
  logic              do_gnt;

  // First asserted request at or above rr, wrapping at N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    req_v = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_v[k] = i_req[k];
    end
    for (int off = 0; off < N_REQ; off++) begin
      cand = RW'((int'(rr_q) + off) % N_REQ);
      if (!found && i_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    do_gnt = i_rst_n && (state_q == IDLE) && !i_clr && found;
    gnt_v  = '0;
    if (do_gnt) begin
      gnt_v[win] = 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      o_gnt[k] = gnt_v[k];
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sidx_d  = sidx_q;
    arr_d   = arr_q;
    unique case (state_q)
      IDLE: begin
        if (i_clr) begin
          state_d = SWEEP;
          sidx_d  = '0;
        end else if (found) begin
          rr_d = RW'((int'(win) + 1) % N_REQ);
          // Out-of-range targets are granted but dropped.
          if (int'(i_idx[win]) < DEPTH) begin
            arr_d[i_idx[win]] = i_data[win];
          end
        end
      end
      SWEEP: begin
        arr_d[sidx_q] = CLR_VAL;
        sidx_d        = sidx_q + 1'b1;
        if (int'(sidx_q) == DEPTH - 1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SWEEP);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      sidx_q  <= '0;
      busy_q  <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        arr_q[e] <= '0;
      end
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sidx_q  <= sidx_d;
      busy_q  <= busy_d;
      arr_q   <= arr_d;
    end
  end

  assign o_busy = busy_q;
  assign o_arr  = arr_q;

`ifdef ARRAY_WR_SCHED_STALL_CNT_EN
  logic [7:0] stall_q, stall_d;

  // A clear cycle grants nothing, so every request then counts as lost.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && ((req_v & ~gnt_v) != '0)
        && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_array_wr_sched.sv
// Scoreboard bench for array_wr_sched: random and directed traffic
// checked against a queue-fed behavioural model.
module tb_array_wr_sched;

  localparam int N = 4;
  localparam int D = 8;
  localparam int W = 8;
  localparam logic [W-1:0] CLR = 8'h5A;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         req  [N];
  logic [2:0]   idx  [N];
  logic [W-1:0] data [N];
  logic         gnt  [N];
  logic         busy;
  logic [W-1:0] arr  [D];
`ifdef ARRAY_WR_SCHED_STALL_CNT_EN
  logic [7:0]   stall;
`endif

  always #5 clk = ~clk;

  array_wr_sched #(
    .N_REQ(N), .DEPTH(D), .WIDTH(W), .CLR_VAL(CLR)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req(req),
    .i_idx(idx),
    .i_data(data),
    .o_gnt(gnt),
    .i_clr(clr),
    .o_busy(busy),
    .o_arr(arr)
`ifdef ARRAY_WR_SCHED_STALL_CNT_EN
    ,
    .o_stall_cnt(stall)
`endif
  );

  typedef struct packed {
    logic [D*W-1:0] arr;
    logic           busy;
    logic [7:0]     stall;
  } st_t;

  logic [N-1:0] gq [$];
  st_t          sq [$];

  int n_pass = 0;
  int n_chk  = 0;

  logic [W-1:0] m_arr [D];
  int           m_rr = 0;
  int           m_sidx = 0;
  int           m_stall = 0;
  bit           m_sweep = 0;
  bit           pend [N];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic apply();
    for (int k = 0; k < N; k++) req[k] = pend[k];
  endtask

  task automatic refresh(input int pct);
    for (int k = 0; k < N; k++) begin
      if (!pend[k] && $urandom_range(99) < pct) begin
        pend[k] = 1'b1;
        idx[k]  = 3'($urandom_range(D - 1));
        data[k] = W'($urandom);
      end
    end
    apply();
  endtask

  // Drive one cycle at a negedge, advance the model, queue expectations.
  task automatic step(input bit r, input bit c);
    logic [N-1:0] g;
    int           nreq;
    int           k;
    st_t          s;
    rst_n = r;
    clr   = c;
    g     = '0;
    nreq  = 0;
    for (int i = 0; i < N; i++) nreq += int'(req[i]);
    if (!r) begin
      for (int e = 0; e < D; e++) m_arr[e] = '0;
      m_rr = 0; m_sidx = 0; m_stall = 0; m_sweep = 0;
    end else if (m_sweep) begin
      m_arr[m_sidx] = CLR;
      m_sidx++;
      if (m_sidx == D) m_sweep = 0;
    end else if (c) begin
      m_sweep = 1;
      m_sidx  = 0;
      if (nreq > 0 && m_stall < 255) m_stall++;
    end else if (nreq > 0) begin
      k = m_rr;
      while (!req[k]) k = (k + 1) % N;
      g[k] = 1'b1;
      m_arr[idx[k]] = data[k];
      m_rr = (k + 1) % N;
      if (nreq > 1 && m_stall < 255) m_stall++;
    end
    for (int e = 0; e < D; e++) s.arr[e*W +: W] = m_arr[e];
    s.busy  = m_sweep;
    s.stall = 8'(m_stall);
    gq.push_back(g);
    sq.push_back(s);
    for (int i = 0; i < N; i++) if (g[i]) pend[i] = 1'b0;
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [N-1:0]   g;
    logic [D*W-1:0] flat;
    st_t            s;
    forever begin
      @(negedge clk);
      #2;
      if (gq.size() > 0) begin
        g = gq.pop_front();
        for (int k = 0; k < N; k++) flat[k] = gnt[k];
        chk("gnt", 64'(flat[N-1:0]), 64'(g));
      end
      @(posedge clk);
      #1;
      if (sq.size() > 0) begin
        s = sq.pop_front();
        for (int e = 0; e < D; e++) flat[e*W +: W] = arr[e];
        chk("arr", flat, s.arr);
        chk("busy", 64'(busy), 64'(s.busy));
`ifdef ARRAY_WR_SCHED_STALL_CNT_EN
        chk("stall_cnt", 64'(stall), 64'(s.stall));
`endif
      end
    end
  end

  initial begin : driver
    for (int k = 0; k < N; k++) begin
      pend[k] = 0; req[k] = 0; idx[k] = '0; data[k] = '0;
    end
    for (int e = 0; e < D; e++) m_arr[e] = '0;
    @(negedge clk);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    pend[2] = 1; idx[2] = 3'd5; data[2] = 8'hA5;
    apply();
    step(1, 0);
    refresh(0);
    step(1, 0);
    step(0, 0);
    for (int k = 0; k < N; k++) begin
      pend[k] = 1; idx[k] = 3'(k + 1); data[k] = 8'(8'h11 * (k + 1));
    end
    apply();
    for (int i = 0; i < 5; i++) begin
      step(1, 0);
      refresh(100);
    end
    for (int k = 0; k < N; k++) pend[k] = 0;
    pend[1] = 1; idx[1] = 3'd2; data[1] = 8'h77;
    apply();
    step(1, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 0);
      refresh(0);
    end
    step(1, 1);
    for (int i = 0; i < 3; i++) step(1, 0);
    step(0, 0);
    step(1, 0);
    step(1, 0);
    step(1, 1);
    for (int i = 0; i < 12; i++) step(1, (i == 2) || (i == 5));
    for (int i = 0; i < 300; i++) begin
      refresh(100);
      step(1, 0);
    end
    for (int i = 0; i < 1500; i++) begin
      refresh(50);
      step($urandom_range(199) != 0, $urandom_range(24) == 0);
    end
    refresh(0);
    repeat (2) @(posedge clk);
    #2;
    chk("drain", 64'(gq.size() + sq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/array_wr_sched.md
# array_wr_sched

Write scheduler for an interface-held unpacked register array. It shares the array's single write path among `N_REQ` requesters using round-robin arbitration, and sequences a DEPTH-cycle clear sweep across all entries. It sits between requesting logic and the array, which is stored in the block and exported whole as an unpacked output array.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2)
- `DEPTH`, 8, number of array entries (≥2)
- `WIDTH`, 8, bits per entry
- `CLR_VAL`, `'0`, value written to every entry by a sweep

Ports:
- `i_clk`  in  1  clock; all state updates on posedge
- `i_rst_n`  in  1  reset; synchronous, active-low
- `i_req`  in  [N_REQ] unpacked of 1  write request per requester
- `i_idx`  in  [N_REQ] unpacked of $clog2(DEPTH)  target entry per requester
- `i_data`  in  [N_REQ] unpacked of WIDTH  write data per requester
- `o_gnt`  out  [N_REQ] unpacked of 1  one-hot grant, combinational
- `i_clr`  in  1  start clear sweep (level-sampled)
- `o_busy`  out  1  sweep in progress
- `o_arr`  out  [DEPTH] unpacked of WIDTH  current array contents
- `o_stall_cnt`  out  8  lost-arbitration counter (only with macro, see Configuration)

## Operation
- FSM states: IDLE, SWEEP. State resets to IDLE.
- IDLE:
  - If `i_clr`=1, go to SWEEP and reset the sweep index to 0. No grant is issued that cycle; clear wins over any requests.
  - Otherwise, grant the first asserted `i_req` at or after the round-robin pointer `rr`, searching upward with wrap at `N_REQ`.
  - Winner k: `o_gnt[k]`=1, and at the next edge `o_arr[i_idx[k]]` ← `i_data[k]`. `rr` ← (k+1) mod N_REQ.
  - No requests: `rr` holds and the array holds.
- SWEEP:
  - Each cycle, `o_arr[sidx]` ← `CLR_VAL` and `sidx` increments.
  - After writing entry DEPTH-1, return to IDLE.
  - `o_gnt` stays all-zero throughout; `i_clr` is ignored; `rr` holds.
- Handshake: a requester holds `i_req`, `i_idx` and `i_data` stable until it sees `o_gnt` high in a cycle. Grant consumption happens in that same cycle. The requester deasserts, or presents a new request, from the next cycle.
- Out-of-range `i_idx` (≥DEPTH, only possible when DEPTH is not a power of 2): the grant is still issued, the write is dropped, and `rr` advances.
- At most one array write per cycle.

## Timing
- Reset (`i_rst_n`=0 at an edge):
  - State=IDLE, `rr`=0, `sidx`=0.
  - Every `o_arr` entry = 0 (not `CLR_VAL`).
  - `o_busy`=0, `o_stall_cnt`=0.
  - `o_gnt` is forced all-zero while `i_rst_n`=0.
- Reset mid-sweep aborts the sweep; the next cycle is IDLE.
- Grant latency: 0 cycles (combinational from `i_req` and `rr`).
- Write visibility: `o_arr` reflects the write 1 cycle after the grant.
- `o_busy` is registered: high from the first cycle in SWEEP through the last sweep-write cycle, i.e. exactly DEPTH cycles.
- A sweep started at edge t completes at edge t+DEPTH. The first grant is possible in the cycle after t+DEPTH.
- Fairness: a continuously asserted requester is granted within `N_REQ` IDLE cycles.

## Configuration
- Macro: `ARRAY_WR_SCHED_STALL_CNT_EN`.
- Defined:
  - Port `o_stall_cnt` exists.
  - Increments by 1 on each IDLE cycle in which at least one asserted `i_req` is not granted. This includes all requests during an `i_clr` cycle.
  - Saturates at 255.
  - Does not count during SWEEP.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then a single request: `i_req[2]`=1, `i_idx[2]`=5, `i_data[2]`=8'hA5 → `o_gnt[2]`=1 the same cycle; `o_arr[5]`=8'hA5 next cycle; other entries 0; `rr`=3.
- All four requesters held continuously with distinct idx/data → grants in order 0,1,2,3,0 on consecutive cycles, each write lands one cycle after its grant; with macro, `o_stall_cnt` increments each cycle.
- `i_clr` and `i_req[1]` in the same IDLE cycle → no grant; `o_busy` high for exactly 8 cycles; all entries equal `CLR_VAL`; `o_gnt[1]` on the first cycle after `o_busy` falls.
- Reset asserted at sweep cycle 3 → next cycle: IDLE, `o_busy`=0, all entries 0, `o_gnt` all-zero during reset.
- Macro defined, 300 cycles of contention → `o_stall_cnt` saturates at 255 and holds.
- `i_clr` re-asserted during SWEEP → ignored; sweep lasts exactly 8 cycles; no second sweep.
